bus_arbiter_2: RTL



---
 rtl/bus_arbiter_2.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_2.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2
//
// Two-host, one-target bus arbiter. Host 0 (CPU core) and host 1 (DMA or
// debug) share one downstream ren/wen/ready bus. Arbitration is round-robin;
// a grant is held for one full transaction and released on device_ready.
// Every transaction is followed by one IDLE cycle.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a BUSY transaction that sees TIMEOUT_CYCLES cycles without
//   device_ready is aborted. The owner gets host_ready with read data
//   32'hDEADBEEF and timeout_err is set until rst. When the macro is not
//   defined, BUSY waits for device_ready indefinitely and timeout_err is 0.
//
// Parameters:
//   TIMEOUT_CYCLES     stalled BUSY cycles before a forced abort (macro only)
//
// Ports:
//   clk                core clock
//   rst                synchronous reset, active-high
//   host_address       {h1,h0} 32-bit addresses
//   host_data_write    {h1,h0} 32-bit write data
//   host_write_mask    {h1,h0} 4-bit byte enables
//   host_ren           per-host read request
//   host_wen           per-host write request (wins over ren)
//   host_data_read     {h1,h0} read data, valid with host_ready
//   host_ready         per-host one-cycle done pulse
//   device_address     downstream address
//   device_data_write  downstream write data
//   device_write_mask  downstream byte enables
//   device_ren         downstream read strobe
//   device_wen         downstream write strobe
//   device_ready       downstream done strobe
//   device_data_read   downstream read data
//   grant              one-hot current owner, 0 when idle
//   busy               high while a transaction is in flight
//   timeout_err        sticky abort flag
// ---------------------------------------------------------------------------
module bus_arbiter_2 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] host_address,
  input  logic [63:0] host_data_write,
  input  logic [7:0]  host_write_mask,
  input  logic [1:0]  host_ren,
  input  logic [1:0]  host_wen,
  output logic [63:0] host_data_read,
  output logic [1:0]  host_ready,
  output logic [31:0] device_address,
  output logic [31:0] device_data_write,
  output logic [3:0]  device_write_mask,
  output logic        device_ren,
  output logic        device_wen,
  input  logic        device_ready,
  input  logic [31:0] device_data_read,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

  state_t      state_r;
  state_t      state_n;
  logic [1:0]  grant_r;
  logic [1:0]  grant_n;
  logic        last_grant_r;   // index of the host served last
  logic        last_grant_n;
  logic [1:0]  req_s;
  logic        owner_s;        // index of the granted host (valid in BUSY)
  logic        timeout_hit_s;
  logic        done_s;

  assign req_s   = host_ren | host_wen;
  assign owner_s = grant_r[1];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] stall_cnt_r;
  logic             timeout_err_r;

  // The counter holds the number of stalled cycles already seen, so the
  // abort fires in the TIMEOUT_CYCLES-th stalled cycle itself. A same-cycle
  // device_ready takes precedence and completes normally.
  assign timeout_hit_s = (state_r == BUSY) && !device_ready &&
                         (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Stall counter: cleared while idle so it starts at zero on BUSY entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (state_r == IDLE) begin
      stall_cnt_r <= '0;
    end else if (!device_ready) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  assign done_s = (state_r == BUSY) && (device_ready || timeout_hit_s);

  // State, grant and round-robin history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= 2'b00;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_n;
      grant_r      <= grant_n;
      last_grant_r <= last_grant_n;
    end
  end

  // Next-state logic: pick a new owner in IDLE, release it on completion.
  always_comb begin
    state_n      = state_r;
    grant_n      = grant_r;
    last_grant_n = last_grant_r;
    case (state_r)
      IDLE: begin
        if (req_s == 2'b11) begin
          // Tie: the host that was not served last wins.
          grant_n = last_grant_r ? 2'b01 : 2'b10;
          state_n = BUSY;
        end else if (req_s != 2'b00) begin
          grant_n = req_s;
          state_n = BUSY;
        end else begin
          grant_n = 2'b00;
          state_n = IDLE;
        end
      end
      BUSY: begin
        if (done_s) begin
          state_n      = IDLE;
          grant_n      = 2'b00;
          last_grant_n = owner_s;
        end else begin
          state_n = BUSY;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 2'b00;
      end
    endcase
  end

  // Downstream mux and host return path. Combinational so the device sees
  // the owner's request in the first BUSY cycle and host_ready adds no
  // latency over device_ready.
  always_comb begin
    device_address    = 32'h0000_0000;
    device_data_write = 32'h0000_0000;
    device_write_mask = 4'b0000;
    device_ren        = 1'b0;
    device_wen        = 1'b0;
    host_ready        = 2'b00;
    host_data_read    = 64'h0000_0000_0000_0000;
    if (state_r == BUSY) begin
      if (owner_s) begin
        device_address    = host_address[63:32];
        device_data_write = host_data_write[63:32];
        device_write_mask = host_write_mask[7:4];
      end else begin
        device_address    = host_address[31:0];
        device_data_write = host_data_write[31:0];
        device_write_mask = host_write_mask[3:0];
      end
      if (timeout_hit_s) begin
        host_ready[owner_s] = 1'b1;
        if (owner_s) begin
          host_data_read[63:32] = ABORT_DATA;
        end else begin
          host_data_read[31:0] = ABORT_DATA;
        end
      end else begin
        // Write wins over an illegal simultaneous read.
        device_wen = host_wen[owner_s];
        device_ren = host_ren[owner_s] & ~host_wen[owner_s];
        if (device_ready) begin
          host_ready[owner_s] = 1'b1;
          if (owner_s) begin
            host_data_read[63:32] = device_data_read;
          end else begin
            host_data_read[31:0] = device_data_read;
          end
        end else begin
          host_ready = 2'b00;
        end
      end
    end else begin
      host_ready = 2'b00;
    end
  end

  assign grant = grant_r;
  assign busy  = (state_r == BUSY);

endmodule
